// File: rtl/apb_pkg.sv
// Shared APB widths, completer FSM states and the setup-phase request latch.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } apb_slv_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
        logic                  err;
    } apb_req_t;

endpackage

// File: rtl/apb_regfile_mem.sv
// DEPTH x 32 register array: one synchronous write port, one combinational read port.
module apb_regfile_mem
    import apb_pkg::*;
#(
    parameter int unsigned          DEPTH     = 16,
    parameter logic [APB_DATA_W-1:0] RESET_VAL = '0,
    localparam int unsigned         IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [IDX_W-1:0]      widx,
    input  logic [APB_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]      ridx,
    output logic [APB_DATA_W-1:0] rdata
);

    logic [APB_DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= RESET_VAL;
            end
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer in front of a small register file with a fixed number of wait states.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned           DEPTH       = 16,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned           WAIT_STATES = 2,
    parameter logic [APB_DATA_W-1:0] RESET_VAL   = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic [APB_ADDR_W-1:0] paddr_i,
    input  logic                  pwrite_i,
    input  logic [APB_DATA_W-1:0] pwdata_i,
    output logic                  pready_o,
    output logic [APB_DATA_W-1:0] prdata_o,
    output logic                  pslverr_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;

    apb_slv_state_e        state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    apb_req_t              req, req_d;
    logic                  pready_d, pslverr_d;
    logic [APB_DATA_W-1:0] prdata_d;
    logic                  we;
    logic                  setup_err;
    logic [IDX_W-1:0]      ridx;
    logic [APB_DATA_W-1:0] rdata;

    // 33-bit compare so a window ending at the top of the address space cannot wrap
    function automatic logic addr_err(input logic [APB_ADDR_W-1:0] a);
        logic [APB_ADDR_W:0] lo;
        logic [APB_ADDR_W:0] hi;
        lo = {1'b0, BASE_ADDR};
        hi = lo + (APB_ADDR_W+1)'(DEPTH * 4);
        return (a[1:0] != 2'b00) || ({1'b0, a} < lo) || ({1'b0, a} >= hi);
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [APB_ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    assign setup_err = addr_err(paddr_i);
    // Zero-wait reads sample the array at the setup edge, before the latch holds the address
    assign ridx = (state == IDLE) ? idx_of(paddr_i) : idx_of(req.addr);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req       <= '0;
            pready_o  <= 1'b0;
            prdata_o  <= '0;
            pslverr_o <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            req       <= req_d;
            pready_o  <= pready_d;
            prdata_o  <= prdata_d;
            pslverr_o <= pslverr_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        req_d     = req;
        pready_d  = pready_o;
        prdata_d  = prdata_o;
        pslverr_d = pslverr_o;
        we        = 1'b0;
        case (state)
            IDLE: begin
                if (psel_i && !penable_i) begin
                    req_d.addr  = paddr_i;
                    req_d.write = pwrite_i;
                    req_d.wdata = pwdata_i;
                    req_d.err   = setup_err;
                    cnt_d       = CNT_W'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d   = DONE;
                        pready_d  = 1'b1;
                        pslverr_d = setup_err;
                        prdata_d  = (setup_err || pwrite_i) ? '0 : rdata;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!psel_i) begin
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end else if (penable_i) begin
                    cnt_d = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_d   = DONE;
                        pready_d  = 1'b1;
                        pslverr_d = req.err;
                        prdata_d  = (req.err || req.write) ? '0 : rdata;
                    end
                end
            end
            DONE: begin
                if (!psel_i || (penable_i && pready_o)) begin
                    we        = psel_i && req.write && !req.err;
                    state_d   = IDLE;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    apb_regfile_mem #(
        .DEPTH     (DEPTH),
        .RESET_VAL (RESET_VAL)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .widx  (idx_of(req.addr)),
        .wdata (req.wdata),
        .ridx  (ridx),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Three completers (2, 0 and 1 wait states) on one shared APB bus, each with its own psel,
// checked against an array model of every register file.
module tb_apb_slave_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [2:0]  pready;
    logic [31:0] prdata [3];
    logic [2:0]  pslverr;

    int          n_checks = 0;
    int          n_errors = 0;

    int          ws    [3] = '{2, 0, 1};
    int          depth [3] = '{16, 16, 8};
    bit [31:0]   base  [3] = '{32'h0, 32'h0, 32'h1000};
    bit [31:0]   rstv  [3] = '{32'hC0DE_0000, 32'h0, 32'h1111_1111};
    bit [31:0]   model [3][16];

    always #5 clk = ~clk;

    apb_slave_regfile #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(2), .RESET_VAL(32'hC0DE_0000)) u_dut0 (
        .clk(clk), .reset(reset), .psel_i(psel[0]), .penable_i(penable), .paddr_i(paddr),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0]));

    apb_slave_regfile #(.DEPTH(16), .BASE_ADDR(32'h0), .WAIT_STATES(0), .RESET_VAL(32'h0)) u_dut1 (
        .clk(clk), .reset(reset), .psel_i(psel[1]), .penable_i(penable), .paddr_i(paddr),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1]));

    apb_slave_regfile #(.DEPTH(8), .BASE_ADDR(32'h1000), .WAIT_STATES(1), .RESET_VAL(32'h1111_1111)) u_dut2 (
        .clk(clk), .reset(reset), .psel_i(psel[2]), .penable_i(penable), .paddr_i(paddr),
        .pwrite_i(pwrite), .pwdata_i(pwdata), .pready_o(pready[2]), .prdata_o(prdata[2]), .pslverr_o(pslverr[2]));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_err(input int d, input bit [31:0] a);
        longint unsigned la = a;
        longint unsigned lb = base[d];
        return (a[1:0] != 2'b00) || (la < lb) || (la >= lb + longint'(depth[d]) * 4);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 16; i++) model[d][i] = rstv[d];
    endtask

    // Full transfer on completer d; returns at the negedge before the completion edge with
    // psel/penable still high, so a following call produces a back-to-back transfer.
    task automatic xfer(input int d, input bit [31:0] a, input bit w, input bit [31:0] wd,
                        output bit [31:0] rd);
        int        edges;
        bit        e;
        bit [31:0] exp_rd;
        @(negedge clk);
        check_eq("pready_between", 32'(pready), 32'h0);
        psel    = 3'(1 << d);
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = wd;
        @(posedge clk);
        @(negedge clk);
        penable = 1'b1;
        edges   = 0;
        paddr   = $urandom;
        pwdata  = $urandom;
        pwrite  = 1'($urandom);
        while (!pready[d] && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            paddr  = $urandom;
            pwdata = $urandom;
            pwrite = 1'($urandom);
        end
        check_eq("latency", 32'(edges), 32'(ws[d]));
        e      = exp_err(d, a);
        exp_rd = (e || w) ? 32'h0 : model[d][(a - base[d]) >> 2];
        check_eq("pslverr", 32'(pslverr[d]), 32'(e));
        check_eq("prdata", prdata[d], exp_rd);
        if (!e && w) model[d][(a - base[d]) >> 2] = wd;
        rd = prdata[d];
    endtask

    task automatic go_idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            psel    = 3'b000;
            penable = 1'b0;
            check_eq("pready_idle", 32'(pready), 32'h0);
        end
    endtask

    task automatic read_all(input int d);
        bit [31:0] rd;
        for (int i = 0; i < depth[d]; i++) xfer(d, base[d] + 32'(i * 4), 1'b0, 32'h0, rd);
        go_idle(1);
    endtask

    initial begin
        bit [31:0] rd;
        bit [31:0] last_a;
        reset   = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check_eq("rst_pready", 32'(pready[d]), 32'h0);
            check_eq("rst_prdata", prdata[d], 32'h0);
            check_eq("rst_pslverr", 32'(pslverr[d]), 32'h0);
        end
        reset = 1'b0;
        go_idle(2);

        // Write then read with two wait states
        xfer(0, 32'h08, 1'b1, 32'hDEAD_BEEF, rd);
        go_idle(1);
        xfer(0, 32'h08, 1'b0, 32'h0, rd);
        check_eq("ws2_readback", rd, 32'hDEAD_BEEF);
        go_idle(1);

        // Zero wait states
        xfer(1, 32'h3C, 1'b1, 32'h1234_5678, rd);
        xfer(1, 32'h3C, 1'b0, 32'h0, rd);
        check_eq("ws0_readback", rd, 32'h1234_5678);
        go_idle(1);

        // Decode errors leave every register intact
        xfer(0, 32'h40, 1'b1, 32'hFFFF_FFFF, rd);
        xfer(0, 32'h06, 1'b0, 32'h0, rd);
        go_idle(1);
        read_all(0);

        // Back-to-back writes with no idle gap
        xfer(0, 32'h0, 1'b1, 32'hA, rd);
        xfer(0, 32'h4, 1'b1, 32'hB, rd);
        xfer(0, 32'h0, 1'b0, 32'h0, rd);
        check_eq("b2b_r0", rd, 32'hA);
        xfer(0, 32'h4, 1'b0, 32'h0, rd);
        check_eq("b2b_r1", rd, 32'hB);
        go_idle(1);

        // Abort: drop psel in the access phase of a write to reg 4
        @(negedge clk);
        psel = 3'b001; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h55;
        @(posedge clk); @(negedge clk);
        penable = 1'b1;
        check_eq("abort_pready_acc", 32'(pready[0]), 32'h0);
        @(posedge clk); @(negedge clk);
        psel = 3'b000; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            check_eq("abort_pready", 32'(pready[0]), 32'h0);
        end
        xfer(0, 32'h10, 1'b0, 32'h0, rd);
        check_eq("abort_reg4", rd, 32'hC0DE_0000);
        go_idle(1);

        // Reset during the access phase of a read
        @(negedge clk);
        psel = 3'b001; penable = 1'b0; paddr = 32'h08; pwrite = 1'b0;
        @(posedge clk); @(negedge clk);
        penable = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check_eq("rst_mid_pready", 32'(pready[0]), 32'h0);
        reset = 1'b0; psel = 3'b000; penable = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            xfer(0, 32'(i * 4), 1'b0, 32'h0, rd);
            check_eq("rst_regval", rd, 32'hC0DE_0000);
        end
        go_idle(1);

        // Master-style command cycle: write, read back, idle
        for (int r = 0; r < 10; r++) begin
            last_a = base[2] + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 7) == 0) last_a = last_a + 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) last_a = base[2] + 32'h20;
            xfer(2, last_a, 1'b1, $urandom, rd);
            xfer(2, last_a, 1'b0, 32'h0, rd);
            go_idle($urandom_range(1, 3));
        end

        // Random traffic across all three completers
        for (int k = 0; k < 60; k++) begin
            int        d;
            bit [31:0] a;
            d = $urandom_range(0, 2);
            a = base[d] + 32'($urandom_range(0, depth[d] + 1) * 4);
            if ($urandom_range(0, 9) == 0) a = a | 32'h1;
            xfer(d, a, 1'($urandom), $urandom, rd);
            if ($urandom_range(0, 2) == 0) go_idle($urandom_range(1, 2));
        end
        go_idle(1);
        for (int d = 0; d < 3; d++) read_all(d);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule
